// File: rtl/mod_inv.sv
// Modular inverse for the Kyber (q=3329) and Dilithium (q=8380417) moduli via
// Fermat exponentiation a^(q-2), one modular multiply per clock cycle.
module mod_inv (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [22:0] a_i,
    input  logic        select_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [22:0] c_o,
    output logic        err_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SQ   = 2'd1;
    localparam logic [1:0] MUL  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [22:0] Q_KYBER   = 23'd3329;
    localparam logic [22:0] Q_DIL     = 23'd8380417;
    localparam logic [22:0] EXP_KYBER = 23'd3327;
    localparam logic [22:0] EXP_DIL   = 23'd8380415;

    logic [1:0]  state;
    logic [1:0]  next_state;
    logic [22:0] acc;
    logic [22:0] a_reg;
    logic        sel_reg;
    logic        err_reg;
    logic [4:0]  cnt;
    logic        ready_q;

    logic        accept;
    logic        in_range;
    logic        operand_err;
    logic [4:0]  last_cnt;
    logic [4:0]  bit_idx;
    logic [22:0] exponent;
    logic        exp_bit;
    logic        last_bit;
    logic [22:0] mul_b;
    logic [45:0] prod;
    logic [22:0] mod_prod;
    logic [22:0] mul_keep;

    assign accept      = in_valid_i && ready_q && (state == IDLE);
    assign in_range    = select_i ? (a_i < Q_DIL) : (a_i < Q_KYBER);
    assign operand_err = (a_i == 23'd0) || !in_range;

    // The exponent MSB is consumed by loading the accumulator with a, so the
    // counter walks the remaining bits from MSB-1 down to bit 0.
    assign last_cnt = sel_reg ? 5'd21 : 5'd10;
    assign bit_idx  = last_cnt - cnt;
    assign exponent = sel_reg ? EXP_DIL : EXP_KYBER;
    assign exp_bit  = exponent[bit_idx];
    assign last_bit = (cnt == last_cnt);

    assign mul_b    = (state == SQ) ? acc : a_reg;
    assign prod     = {23'd0, acc} * {23'd0, mul_b};
    assign mod_prod = sel_reg ? 23'(prod % 46'd8380417) : 23'(prod % 46'd3329);

    // The multiply always happens in MUL so timing never depends on the exponent bit.
    assign mul_keep = exp_bit ? mod_prod : acc;

    assign in_ready_o  = ready_q;
    assign out_valid_o = (state == DONE);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = SQ;
            SQ:      next_state = MUL;
            MUL:     next_state = last_bit ? DONE : SQ;
            DONE:    if (out_ready_i) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            acc     <= 23'd0;
            a_reg   <= 23'd0;
            sel_reg <= 1'b0;
            err_reg <= 1'b0;
            cnt     <= 5'd0;
            ready_q <= 1'b0;
            c_o     <= 23'd0;
            err_o   <= 1'b0;
        end else begin
            state   <= next_state;
            ready_q <= (next_state == IDLE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg   <= a_i;
                        acc     <= a_i;
                        sel_reg <= select_i;
                        err_reg <= operand_err;
                        cnt     <= 5'd0;
                    end
                end
                SQ: begin
                    acc <= mod_prod;
                end
                MUL: begin
                    acc <= mul_keep;
                    cnt <= cnt + 5'd1;
                    if (last_bit) begin
                        c_o   <= err_reg ? 23'd0 : mul_keep;
                        err_o <= err_reg;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_inv.sv
// Self-checking bench for mod_inv: table vectors, reset/backpressure sequences
// and a random sweep, with expected results queued at issue and popped at output.
module tb_mod_inv;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [22:0] a_i;
    logic        select_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [22:0] c_o;
    logic        err_o;

    int check_count = 0;
    int pass_count  = 0;

    typedef struct {
        logic [22:0] c;
        logic        err;
        int          lat;
        longint      a;
        longint      q;
    } exp_t;

    typedef struct {
        logic [22:0] a;
        logic        sel;
        logic [22:0] c;
        logic        err;
        int          bp;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[12];

    mod_inv dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .select_i    (select_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .c_o         (c_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkVal(input string name, input longint act, input longint req);
        check_count++;
        if (act == req) pass_count++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Extended Euclid, independent of the exponentiation the design uses.
    function automatic longint refInv(input longint a, input longint q);
        longint t, newt, r, newr, quo, tmp;
        if (a == 0 || a >= q) return 0;
        t = 0; newt = 1; r = q; newr = a;
        while (newr != 0) begin
            quo  = r / newr;
            tmp  = t - quo * newt; t = newt; newt = tmp;
            tmp  = r - quo * newr; r = newr; newr = tmp;
        end
        if (t < 0) t = t + q;
        return t;
    endfunction

    task automatic applyStimulus(input logic [22:0] a, input logic sel,
                                 input logic [22:0] c, input logic err);
        exp_t e;
        int w = 0;
        while (!in_ready_o && w < 50) begin
            @(posedge clk_i); #1; w++;
        end
        checkVal("in_ready before accept", longint'(in_ready_o), 1);
        in_valid_i = 1'b1;
        a_i        = a;
        select_i   = sel;
        e.c   = c;
        e.err = err;
        e.lat = sel ? 44 : 22;
        e.a   = longint'(a);
        e.q   = sel ? 64'd8380417 : 64'd3329;
        sb.push_back(e);
        @(posedge clk_i); #1;
        // Junk held on the inputs while busy must be ignored.
        a_i      = 23'h5A5A5;
        select_i = ~sel;
    endtask

    task automatic checkOutput(input int bp, input string tag);
        exp_t        e;
        int          lat = 0;
        logic [22:0] held_c;
        logic        held_err;
        logic        stable;
        if (sb.size() == 0) begin
            checkVal({tag, " scoreboard empty"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        while (!out_valid_o && lat < 200) begin
            @(posedge clk_i); #1; lat++;
        end
        checkVal({tag, " latency"}, lat, e.lat);
        checkVal({tag, " c_o"}, longint'(c_o), longint'(e.c));
        checkVal({tag, " err_o"}, longint'(err_o), longint'(e.err));
        if (!e.err)
            checkVal({tag, " a*c mod q"}, (e.a * longint'(c_o)) % e.q, 1);
        held_c   = c_o;
        held_err = err_o;
        if (bp > 0) begin
            stable = 1'b1;
            repeat (bp) begin
                @(posedge clk_i); #1;
                if (!out_valid_o || c_o != held_c || err_o != held_err || in_ready_o)
                    stable = 1'b0;
            end
            checkVal({tag, " backpressure stable"}, longint'(stable), 1);
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        checkVal({tag, " out_valid after handshake"}, longint'(out_valid_o), 0);
        checkVal({tag, " c_o held after handshake"}, longint'(c_o), longint'(held_c));
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [22:0] ra;
        logic [22:0] rc;

        vecs[0]  = '{23'd17,      1'b0, 23'd1175,    1'b0, 0};
        vecs[1]  = '{23'd2,       1'b1, 23'd4190209, 1'b0, 0};
        vecs[2]  = '{23'd8380416, 1'b1, 23'd8380416, 1'b0, 0};
        vecs[3]  = '{23'd0,       1'b0, 23'd0,       1'b1, 0};
        vecs[4]  = '{23'd3329,    1'b0, 23'd0,       1'b1, 0};
        vecs[5]  = '{23'd8380417, 1'b1, 23'd0,       1'b1, 0};
        vecs[6]  = '{23'd3328,    1'b0, 23'd3328,    1'b0, 10};
        vecs[7]  = '{23'h001005,  1'b0, 23'd0,       1'b1, 0};
        vecs[8]  = '{23'd1,       1'b1, 23'd1,       1'b0, 0};
        vecs[9]  = '{23'd0,       1'b1, 23'd0,       1'b1, 3};
        vecs[10] = '{23'd1,       1'b0, 23'd1,       1'b0, 0};
        vecs[11] = '{23'd3,       1'b0, 23'd1110,    1'b0, 0};

        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        a_i         = 23'd0;
        select_i    = 1'b0;
        #2;
        checkVal("reset in_ready", longint'(in_ready_o), 0);
        checkVal("reset out_valid", longint'(out_valid_o), 0);
        checkVal("reset c_o", longint'(c_o), 0);
        checkVal("reset err_o", longint'(err_o), 0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(posedge clk_i); #1;
        checkVal("in_ready after reset release", longint'(in_ready_o), 1);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].a, vecs[i].sel, vecs[i].c, vecs[i].err);
            checkOutput(vecs[i].bp, $sformatf("vec%0d", i));
        end

        // Abort a Kyber operation mid-flight, then confirm a clean restart.
        applyStimulus(23'd1234, 1'b0, 23'(refInv(1234, 3329)), 1'b0);
        repeat (9) @(posedge clk_i);
        #1 rst_i = 1'b1;
        #1;
        void'(sb.pop_front());
        checkVal("mid reset in_ready", longint'(in_ready_o), 0);
        checkVal("mid reset out_valid", longint'(out_valid_o), 0);
        checkVal("mid reset c_o", longint'(c_o), 0);
        checkVal("mid reset err_o", longint'(err_o), 0);
        in_valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(posedge clk_i); #1;
        checkVal("in_ready after mid reset", longint'(in_ready_o), 1);
        applyStimulus(23'd1, 1'b0, 23'd1, 1'b0);
        checkOutput(0, "post reset a=1");

        for (int i = 0; i < 24; i++) begin
            if (i % 2 == 0) begin
                ra = 23'($urandom_range(1, 3328));
                rc = 23'(refInv(longint'(ra), 3329));
                applyStimulus(ra, 1'b0, rc, 1'b0);
            end else begin
                ra = 23'($urandom_range(1, 8380416));
                rc = 23'(refInv(longint'(ra), 8380417));
                applyStimulus(ra, 1'b1, rc, 1'b0);
            end
            checkOutput(0, $sformatf("rand%0d a=%0d", i, ra));
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/mod_inv.md
MOD_INV -- requirements
Module: mod_inv

Interface
REQ-001 Parameters: none; moduli are fixed: Kyber q=3329 (12-bit), Dilithium q=8380417 (23-bit).
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 in_valid_i  input  1  operand a_i/select_i valid.
REQ-005 in_ready_o  output  1  block can accept an operand.
REQ-006 a_i  input  23  operand; Kyber uses [11:0], [22:12] must be zero.
REQ-007 select_i  input  1  1 = Dilithium modulus, 0 = Kyber modulus.
REQ-008 out_valid_o  output  1  result valid.
REQ-009 out_ready_i  input  1  consumer accepts result.
REQ-010 c_o  output  23  a^-1 mod q; Kyber result zero-extended to 23 bits.
REQ-011 err_o  output  1  operand non-invertible or out of range; qualified by out_valid_o.

Function
REQ-012 Computes c = a^(q-2) mod q (Fermat); exponent 3327 (Kyber) or 8380415 (Dilithium).
REQ-013 Method: left-to-right square-and-multiply; accumulator loaded with a (exponent MSB is 1), then one SQ and one MUL cycle per remaining exponent bit, MSB-1 down to bit 0.
REQ-014 Constant-time: MUL cycle always executes; result kept only if exponent bit is 1, else accumulator unchanged.
REQ-015 Each SQ/MUL cycle = one full 23x23 multiply plus reduction mod selected q, completed within that cycle.
REQ-016 States: IDLE, SQ, MUL, DONE.
REQ-017 IDLE: in_ready_o=1; in_valid_i&in_ready_o at an edge latches a_i, select_i, clears bit counter, goes to SQ.
REQ-018 SQ -> MUL unconditionally; MUL -> SQ if bits remain, else DONE.
REQ-019 Compute cycles: exactly 22 (Kyber, 11 bits) or 44 (Dilithium, 22 bits), independent of a_i value.
REQ-020 out_valid_o first high 22 (Kyber) / 44 (Dilithium) cycles after the accepting edge; registered output.
REQ-021 DONE: out_valid_o=1, c_o/err_o stable until the edge where out_ready_i=1; then IDLE.
REQ-022 in_ready_o=0 in SQ, MUL, DONE; new operand earliest one cycle after output handshake.
REQ-023 a_i, select_i, in_valid_i changes after acceptance ignored.
REQ-024 a==0: full latency, c_o=0, err_o=1.
REQ-025 a>=q for selected modulus (incl. nonzero a_i[22:12] in Kyber mode): full latency, c_o=0, err_o=1.
REQ-026 Valid a (1..q-1): err_o=0, c_o in [1,q-1], a*c_o mod q = 1.
REQ-027 c_o, err_o hold last value outside DONE; only meaningful while out_valid_o=1.

Reset
REQ-028 rst_i high, any time incl. mid-computation: state IDLE, in_ready_o=0 while rst_i high, out_valid_o=0, c_o=0, err_o=0, accumulator and counter cleared; in-flight operation discarded.
REQ-029 First rising edge with rst_i low: in_ready_o=1 thereafter in IDLE.

Verification
REQ-030 Kyber a=17 -> c_o=1175, err_o=0, out_valid_o exactly 22 cycles after accept.
REQ-031 Dilithium a=2 -> c_o=4190209; a=8380416 -> c_o=8380416; out_valid_o 44 cycles after accept.
REQ-032 Kyber a=0 and a=3329, Dilithium a=8380417 -> c_o=0, err_o=1, same latency as valid operands.
REQ-033 Backpressure: out_ready_i low 10 cycles in DONE -> c_o/err_o/out_valid_o stable, in_ready_o=0; handshake then IDLE.
REQ-034 Reset at MUL cycle 5, then Kyber a=1 -> c_o=1 after 22 cycles, no residue of aborted op.
REQ-035 Random sweep both moduli: a*c_o mod q = 1 for all a in [1,q-1]; latency constant.
